gamma_dither_out: RTL and testbench

//  Downstream stage of the 8-bit->12-bit gamma LUTs. Takes a CH-channel 12-bit gamma-corrected video stream and requantises it to OUT_W bits.

---
 rtl/gamma_pkg.sv | 29 ++
 rtl/gamma_dither_out_dither_ch.sv | 46 ++++
 rtl/gamma_dither_out.sv | 107 ++++++++++
 tb/tb_gamma_dither_out.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared widths and the per-channel quantiser used by the gamma dither output stage.
// Combinational helper only; no state and no flow control live here.
package gamma_pkg;

    localparam int GAMMA_IN_W  = 12;
    localparam int GAMMA_OUT_W = 8;
    localparam int GAMMA_DROP  = GAMMA_IN_W - GAMMA_OUT_W;

    // Half an output LSB, used as the error seed on alternating lines/frames.
    localparam logic [GAMMA_DROP-1:0] GAMMA_SEED_HALF = GAMMA_DROP'(1) << (GAMMA_DROP - 1);

    // Returns {out, err_next}; with dithering off the low bits (err_next) are zero.
    function automatic logic [GAMMA_IN_W-1:0] sat_slice(
        input logic                  en,
        input logic [GAMMA_IN_W-1:0] data,
        input logic [GAMMA_DROP-1:0] err
    );
        logic [GAMMA_IN_W:0] sum;
        sum = {1'b0, data} + {{(GAMMA_OUT_W + 1){1'b0}}, err};
        if (!en) begin
            return {data[GAMMA_IN_W-1:GAMMA_DROP], {GAMMA_DROP{1'b0}}};
        end else if (sum[GAMMA_IN_W]) begin
            return {{GAMMA_OUT_W{1'b1}}, {GAMMA_DROP{1'b0}}};
        end else begin
            return sum[GAMMA_IN_W-1:0];
        end
    endfunction

endpackage

// File: rtl/gamma_dither_out_dither_ch.sv
// One colour channel: error register plus quantiser, output registered.
// Latency 1 cycle from the stage-1 pixel; no backpressure (always accepts).
// Error feedback (mux + add + slice) closes inside a single cycle.
module dither_ch
    import gamma_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   de,
    input  logic                   de_rise,
    input  logic [GAMMA_DROP-1:0]  seed,
    input  logic [GAMMA_IN_W-1:0]  data,
    output logic [GAMMA_OUT_W-1:0] out_dat
);

    logic [GAMMA_DROP-1:0]  err_q, err_d, err_use;
    logic [GAMMA_OUT_W-1:0] out_q, out_d;
    logic [GAMMA_IN_W-1:0]  q_res;

    always_comb begin
        // First pixel of a line starts from the seed, never from old residue.
        err_use = de_rise ? seed : err_q;
        q_res   = sat_slice(en, data, err_use);
        if (de) begin
            out_d = q_res[GAMMA_IN_W-1:GAMMA_DROP];
            err_d = q_res[GAMMA_DROP-1:0];
        end else begin
            out_d = '0;
            err_d = seed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            out_q <= '0;
        end else begin
            err_q <= err_d;
            out_q <= out_d;
        end
    end

    assign out_dat = out_q;

endmodule

// File: rtl/gamma_dither_out.sv
// Requantises CH gamma-corrected channels with seeded horizontal error diffusion.
// Fixed 2-cycle latency for data and syncs; no backpressure.
// Channel widths follow the gamma_pkg quantiser.
module gamma_dither_out
    import gamma_pkg::*;
#(
    parameter int CH    = 3,
    parameter int IN_W  = GAMMA_IN_W,
    parameter int OUT_W = GAMMA_OUT_W
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic                I_dither_en,
    input  logic                I_vs,
    input  logic                I_hs,
    input  logic                I_de,
    input  logic [CH*IN_W-1:0]  I_data,
    output logic                O_vs,
    output logic                O_hs,
    output logic                O_de,
    output logic [CH*OUT_W-1:0] O_data
);

    logic               vs1_q, hs1_q, de1_q, en1_q;
    logic               vs1_d, hs1_d, de1_d, en1_d;
    logic [CH*IN_W-1:0] data1_q, data1_d;
    logic               vs2_q, hs2_q, de2_q;
    logic               vs2_d, hs2_d, de2_d;
    logic               en_q, frame_odd_q, line_odd_q;
    logic               en_d, frame_odd_d, line_odd_d;
    logic               vs_rise, de_rise, de_fall;
    logic [GAMMA_DROP-1:0] seed;

    always_comb begin
        vs1_d   = I_vs;
        hs1_d   = I_hs;
        de1_d   = I_de;
        en1_d   = I_dither_en;
        data1_d = I_data;
        vs2_d   = vs1_q;
        hs2_d   = hs1_q;
        de2_d   = de1_q;

        // Edges are taken on stage 1 so vs and de events share one timebase.
        vs_rise = vs1_q & ~vs2_q;
        de_rise = de1_q & ~de2_q;
        de_fall = ~de1_q & de2_q;

        en_d        = vs_rise ? en1_q : en_q;
        frame_odd_d = vs_rise ? ~frame_odd_q : frame_odd_q;
        if (vs_rise) begin
            line_odd_d = 1'b0;
        end else if (de_fall) begin
            line_odd_d = ~line_odd_q;
        end else begin
            line_odd_d = line_odd_q;
        end

        seed = (frame_odd_q ^ line_odd_q) ? GAMMA_SEED_HALF : '0;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            vs1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            en1_q       <= 1'b0;
            data1_q     <= '0;
            vs2_q       <= 1'b0;
            hs2_q       <= 1'b0;
            de2_q       <= 1'b0;
            en_q        <= 1'b0;
            frame_odd_q <= 1'b0;
            line_odd_q  <= 1'b0;
        end else begin
            vs1_q       <= vs1_d;
            hs1_q       <= hs1_d;
            de1_q       <= de1_d;
            en1_q       <= en1_d;
            data1_q     <= data1_d;
            vs2_q       <= vs2_d;
            hs2_q       <= hs2_d;
            de2_q       <= de2_d;
            en_q        <= en_d;
            frame_odd_q <= frame_odd_d;
            line_odd_q  <= line_odd_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        dither_ch u_ch (
            .clk     (I_clk),
            .rst     (I_rst),
            .en      (en_q),
            .de      (de1_q),
            .de_rise (de_rise),
            .seed    (seed),
            .data    (data1_q[g*IN_W +: IN_W]),
            .out_dat (O_data[g*OUT_W +: OUT_W])
        );
    end

    assign O_vs = vs2_q;
    assign O_hs = hs2_q;
    assign O_de = de2_q;

endmodule

// File: tb/tb_gamma_dither_out.sv
// Directed bench for gamma_dither_out: truncation, seeded diffusion, frame-latched
// enable and mid-line reset, each checked 2 cycles after the stimulus.
module tb_gamma_dither_out;

    logic        I_clk = 1'b0;
    logic        I_rst, I_dither_en, I_vs, I_hs, I_de;
    logic [35:0] I_data;
    logic        O_vs, O_hs, O_de;
    logic [23:0] O_data;

    gamma_dither_out dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_dither_en (I_dither_en),
        .I_vs        (I_vs),
        .I_hs        (I_hs),
        .I_de        (I_de),
        .I_data      (I_data),
        .O_vs        (O_vs),
        .O_hs        (O_hs),
        .O_de        (O_de),
        .O_data      (O_data)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] dat;
    } exp_t;

    exp_t pipe0, pipe1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Pixel pattern: ch2=FFF (saturation), ch1=004, ch0=008.
    localparam logic [35:0] PX  = {12'hFFF, 12'h004, 12'h008};
    localparam logic [35:0] PX2 = {12'hFFF, 12'h00F, 12'hABC};

    // Expected outputs for 4 PX pixels: seed 0, seed 8, truncation.
    logic [23:0] exp_s0 [4] = '{24'hFF0000, 24'hFF0001, 24'hFF0000, 24'hFF0101};
    logic [23:0] exp_s8 [4] = '{24'hFF0001, 24'hFF0100, 24'hFF0001, 24'hFF0000};
    logic [23:0] exp_tr [4] = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_pipe();
        chk("o_vs",   32'(O_vs),   32'(pipe1.vs));
        chk("o_hs",   32'(O_hs),   32'(pipe1.hs));
        chk("o_de",   32'(O_de),   32'(pipe1.de));
        chk("o_data", 32'(O_data), 32'(pipe1.dat));
    endtask

    task automatic chk_zero();
        chk("rst_vs",   32'(O_vs),   32'h0);
        chk("rst_hs",   32'(O_hs),   32'h0);
        chk("rst_de",   32'(O_de),   32'h0);
        chk("rst_data", 32'(O_data), 32'h0);
    endtask

    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [35:0] d, input logic [23:0] e);
        @(negedge I_clk);
        chk_pipe();
        pipe1  = pipe0;
        pipe0  = {vs, hs, de, e};
        I_vs   = vs;
        I_hs   = hs;
        I_de   = de;
        I_data = d;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 36'h0, 24'h0);
    endtask

    task automatic vs_pulse();
        step(1'b1, 1'b0, 1'b0, 36'h0, 24'h0);
        blank(2);
    endtask

    task automatic line4(input int sel);
        logic [23:0] e;
        step(1'b0, 1'b1, 1'b0, 36'h0, 24'h0);
        blank(2);
        for (int i = 0; i < 4; i++) begin
            e = (sel == 0) ? exp_s0[i] : (sel == 1) ? exp_s8[i] : exp_tr[i];
            step(1'b0, 1'b0, 1'b1, PX, e);
        end
        blank(3);
    endtask

    // Reset for n cycles with random sync/data; enable is left as set.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge I_clk);
            if (i == 0) chk_pipe();
            else chk_zero();
            I_rst  = 1'b1;
            I_vs   = 1'($urandom);
            I_hs   = 1'($urandom);
            I_de   = 1'($urandom);
            I_data = {4'($urandom), $urandom};
        end
        @(negedge I_clk);
        chk_zero();
        I_rst  = 1'b0;
        I_vs   = 1'b0;
        I_hs   = 1'b0;
        I_de   = 1'b0;
        I_data = '0;
        pipe0  = '0;
        pipe1  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_rst       = 1'b1;
        I_dither_en = 1'($urandom);
        I_vs        = 1'b1;
        I_hs        = 1'b1;
        I_de        = 1'b1;
        I_data      = 36'hFFF_ABC_123;
        pipe0       = '0;
        pipe1       = '0;

        do_reset(3);

        // Plain truncation; en latched as 0 on the first vs rise.
        I_dither_en = 1'b0;
        blank(2);
        vs_pulse();
        step(1'b0, 1'b1, 1'b0, 36'h0, 24'h0);
        blank(1);
        step(1'b0, 1'b0, 1'b1, PX2, 24'hFF00AB);
        step(1'b0, 1'b0, 1'b1, PX2, 24'hFF00AB);
        blank(3);

        // Dithering frame with frame parity back to even: line 0 seed 0, line 1 seed 8.
        I_dither_en = 1'b1;
        vs_pulse();
        line4(0);
        line4(1);

        // Mid-frame disable has no effect until the next vs rise.
        I_dither_en = 1'b0;
        line4(0);
        vs_pulse();
        line4(2);
        I_dither_en = 1'b1;
        line4(2);

        // Two frames on: odd frame, line 0 -> seed 8; reset with err=8 pending.
        vs_pulse();
        vs_pulse();
        step(1'b0, 1'b1, 1'b0, 36'h0, 24'h0);
        blank(2);
        step(1'b0, 1'b0, 1'b1, PX, exp_s8[0]);
        step(1'b0, 1'b0, 1'b1, PX, exp_s8[1]);
        step(1'b0, 1'b0, 1'b1, PX, exp_s8[2]);
        do_reset(2);

        // After reset, two frame starts give frame 0 / line 0 -> seed 0.
        blank(2);
        vs_pulse();
        vs_pulse();
        line4(0);
        blank(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
